// File: rtl/activation_pkg.sv
// Shared types, default formats and the sigmoid/tanh ROM contents for the activation pipe.
// ROM entries are round(f(x_i) * 4096) sampled at x_i = -8 + i/4, i = 0..63 (Q4.12).
package activation_pkg;

    typedef enum logic [1:0] {ACT_ID, ACT_RELU, ACT_SIG, ACT_TANH} act_mode_e;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 12;
    localparam int LUT_A_DEF  = 6;
    localparam int LANES_DEF  = 4;

    localparam int SIG_ROM [64] = '{
           1,    2,    2,    3,    4,    5,    6,    8,
          10,   13,   17,   21,   27,   35,   45,   58,
          74,   94,  120,  153,  194,  246,  311,  391,
         488,  606,  747,  912, 1102, 1314, 1546, 1793,
        2048, 2303, 2550, 2782, 2994, 3184, 3349, 3490,
        3608, 3705, 3785, 3850, 3902, 3943, 3976, 4002,
        4022, 4038, 4051, 4061, 4069, 4075, 4079, 4083,
        4086, 4088, 4090, 4091, 4092, 4093, 4094, 4094
    };

    localparam int TANH_ROM [64] = '{
        -4096, -4096, -4096, -4096, -4096, -4096, -4096, -4096,
        -4096, -4096, -4096, -4096, -4096, -4095, -4095, -4094,
        -4093, -4091, -4089, -4084, -4076, -4063, -4041, -4006,
        -3949, -3856, -3707, -3475, -3119, -2602, -1893, -1003,
            0,  1003,  1893,  2602,  3119,  3475,  3707,  3856,
         3949,  4006,  4041,  4063,  4076,  4084,  4089,  4091,
         4093,  4094,  4095,  4095,  4096,  4096,  4096,  4096,
         4096,  4096,  4096,  4096,  4096,  4096,  4096,  4096
    };

    function automatic logic signed [DATA_W_DEF-1:0] sig_lut(input logic [LUT_A_DEF-1:0] i);
        return DATA_W_DEF'(SIG_ROM[i]);
    endfunction

    function automatic logic signed [DATA_W_DEF-1:0] tanh_lut(input logic [LUT_A_DEF-1:0] i);
        return DATA_W_DEF'(TANH_ROM[i]);
    endfunction

endpackage

// File: rtl/activation_lut.sv
// Combinational dual-read activation ROM: the segment start point and its right-hand neighbour.
// The neighbour of the last segment is the last entry itself, so the top of the range never wraps.
module activation_lut
    import activation_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LUT_A  = LUT_A_DEF
) (
    input  act_mode_e                 mode,
    input  logic [LUT_A-1:0]          idx,
    output logic signed [DATA_W-1:0]  y0,
    output logic signed [DATA_W-1:0]  y1
);

    localparam logic [LUT_A-1:0] IDX_MAX = '1;

    logic [LUT_A-1:0] idx_nxt;

    always_comb begin
        idx_nxt = (idx == IDX_MAX) ? idx : idx + 1'b1;
        y0      = '0;
        y1      = '0;
        case (mode)
            ACT_SIG: begin
                y0 = sig_lut(idx);
                y1 = sig_lut(idx_nxt);
            end
            ACT_TANH: begin
                y0 = tanh_lut(idx);
                y1 = tanh_lut(idx_nxt);
            end
            default: begin
                y0 = '0;
                y1 = '0;
            end
        endcase
    end

endmodule

// File: rtl/activation_pipe.sv
// Three-stage multi-lane activation pipe (index, lookup, interpolate) behind one valid/ready handshake.
// A single stall signal freezes every stage; bubbles advance whenever the output is not blocked.
module activation_pipe
    import activation_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int LUT_A  = LUT_A_DEF,
    parameter int LANES  = LANES_DEF
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_mode,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data
);

    localparam int FR_W = DATA_W - LUT_A;
    localparam int PW   = DATA_W + 1 + FR_W + 1;
    localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    if (FRAC_W >= DATA_W || LUT_A >= DATA_W) begin : g_bad_param
        $error("activation_pipe: FRAC_W and LUT_A must be narrower than DATA_W");
    end

    logic      ready_en;
    logic      stall;
    logic      adv;
    logic      v1, v2, v3;
    act_mode_e m1, m2;

    assign stall     = v3 & ~out_ready;
    assign adv       = ~stall;
    assign in_ready  = ready_en & ~stall;
    assign out_valid = v3;

    // ready_en keeps the input closed for the first edge after reset release
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ready_en <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            m1       <= ACT_ID;
            m2       <= ACT_ID;
        end else begin
            ready_en <= 1'b1;
            if (adv) begin
                v1 <= in_valid & in_ready;
                v2 <= v1;
                v3 <= v2;
                m1 <= act_mode_e'(in_mode);
                m2 <= m1;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [DATA_W-1:0] x0, x1, x2;
        logic [DATA_W-1:0]        u0;
        logic [LUT_A-1:0]         idx1;
        logic [FR_W-1:0]          frac1, frac2;
        logic signed [DATA_W-1:0] y0_c, y1_c, y0_2, y1_2;
        logic signed [PW-1:0]     diff, fs, prod, shr, sum;
        logic signed [DATA_W-1:0] y3, y_q;

        assign x0 = in_data[i*DATA_W +: DATA_W];
        assign u0 = {~x0[DATA_W-1], x0[DATA_W-2:0]};

        activation_lut #(.DATA_W(DATA_W), .LUT_A(LUT_A)) u_lut (
            .mode (m1),
            .idx  (idx1),
            .y0   (y0_c),
            .y1   (y1_c)
        );

        always_comb begin
            diff = PW'(y1_2) - PW'(y0_2);
            fs   = PW'({1'b0, frac2});
            prod = diff * fs;
            shr  = prod >>> FR_W;
            sum  = shr + PW'(y0_2);
            y3   = '0;
            case (m2)
                ACT_ID:   y3 = x2;
                ACT_RELU: y3 = x2[DATA_W-1] ? '0 : x2;
                default: begin
                    if (sum[PW-1:DATA_W-1] == '0 || sum[PW-1:DATA_W-1] == '1)
                        y3 = sum[DATA_W-1:0];
                    else
                        y3 = sum[PW-1] ? Y_MIN : Y_MAX;
                end
            endcase
        end

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                idx1  <= '0;
                frac1 <= '0;
                x1    <= '0;
                y0_2  <= '0;
                y1_2  <= '0;
                frac2 <= '0;
                x2    <= '0;
                y_q   <= '0;
            end else if (adv) begin
                idx1  <= u0[DATA_W-1 -: LUT_A];
                frac1 <= u0[FR_W-1:0];
                x1    <= x0;
                y0_2  <= y0_c;
                y1_2  <= y1_c;
                frac2 <= frac1;
                x2    <= x1;
                y_q   <= y3;
            end
        end

        assign out_data[i*DATA_W +: DATA_W] = y_q;
    end

endmodule

// File: tb/tb_activation_pipe.sv
// Bench for activation_pipe: real-valued reference model with an in-order scoreboard checked every cycle.
module tb_activation_pipe;

    localparam int DW = 16;
    localparam int NL = 4;

    typedef struct packed {
        logic [1:0]       mode;
        logic [NL*DW-1:0] data;
    } vec_t;

    logic             tb_clk;
    logic             n_rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [NL*DW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [NL*DW-1:0] out_data;

    int               total = 0;
    int               bad   = 0;
    int               lut_tab [4][64];
    logic [NL*DW-1:0] exp_q [$];
    vec_t             vecs [$];
    int               age;
    logic             prev_stall = 1'b0;
    logic [NL*DW-1:0] prev_data  = '0;

    activation_pipe dut (
        .clk       (tb_clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    function automatic int rnd(input real v);
        return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
    endfunction

    // Reference: sample the real function on the 64 grid points, then interpolate with plain arithmetic.
    function automatic logic [15:0] model_lane(input logic [1:0] mode, input logic [15:0] x);
        int xs, pos, seg, off, y0, y1, y;
        xs = int'($signed(x));
        if (mode == 2'd0) return x;
        if (mode == 2'd1) return (xs < 0) ? 16'h0000 : x;
        pos = xs + 32768;
        seg = pos / 1024;
        off = pos % 1024;
        y0  = lut_tab[mode][seg];
        y1  = lut_tab[mode][(seg == 63) ? seg : seg + 1];
        y   = y0 + int'($floor(real'((y1 - y0) * off) / 1024.0));
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return 16'(y);
    endfunction

    function automatic logic [NL*DW-1:0] model_beat(input logic [1:0] mode, input logic [NL*DW-1:0] d);
        logic [NL*DW-1:0] r;
        r = '0;
        for (int l = 0; l < NL; l++) r[l*DW +: DW] = model_lane(mode, d[l*DW +: DW]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    always @(posedge tb_clk or negedge n_rst) begin
        if (!n_rst) age <= 0;
        else if (age < 4) age <= age + 1;
    end

    // Per-cycle compare, sampled mid-cycle; handshakes seen here complete on the following rising edge.
    always @(negedge tb_clk) begin
        if (!n_rst) begin
            check("reset_out", {63'(out_data != '0), out_valid}, 64'h0);
            prev_stall = 1'b0;
        end else begin
            check("in_ready", {63'h0, in_ready}, {63'h0, (age >= 1) && !(out_valid && !out_ready)});
            if (prev_stall) begin
                check("hold_valid", {63'h0, out_valid}, 64'h1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat got=%h exp=none", out_data);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model_beat(in_mode, in_data));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // ready_kind: 0 always ready, 1 pattern 1,0,0 repeating, 2 random 70%
    task automatic run_stream(input int valid_pct, input int ready_kind, input int budget);
        int   vi  = 0;
        int   cyc = 0;
        logic hs;
        while ((vi < vecs.size() || exp_q.size() != 0) && cyc < budget) begin
            if (vi < vecs.size()) begin
                in_valid = ($urandom_range(99) < valid_pct);
                in_mode  = vecs[vi].mode;
                in_data  = vecs[vi].data;
            end else begin
                in_valid = 1'b0;
            end
            case (ready_kind)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = ($urandom_range(99) < 70);
            endcase
            @(negedge tb_clk);
            hs = in_valid && in_ready;
            @(posedge tb_clk);
            #1;
            if (hs) vi++;
            cyc++;
        end
        if (cyc >= budget) begin
            total++;
            bad++;
            $display("FAIL stream_timeout got=%0d left exp=0", vecs.size() - vi + exp_q.size());
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vecs.delete();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            real xi;
            xi = -8.0 + real'(i) * 0.25;
            lut_tab[0][i] = 0;
            lut_tab[1][i] = 0;
            lut_tab[2][i] = rnd(4096.0 / (1.0 + $exp(-xi)));
            lut_tab[3][i] = rnd(4096.0 * $tanh(xi));
        end

        // hand-computed pins on the reference itself
        check("pin_sig_0",      {48'h0, model_lane(2, 16'h0000)}, 64'h0800);
        check("pin_sig_min",    {48'h0, model_lane(2, 16'h8000)}, 64'h0001);
        check("pin_sig_max",    {48'h0, model_lane(2, 16'h7FFF)}, 64'h0FFE);
        check("pin_sig_m1",     {48'h0, model_lane(2, 16'hF000)}, 64'h044E);
        check("pin_tanh_m1",    {48'h0, model_lane(3, 16'hF000)}, 64'hF3D1);
        check("pin_tanh_min",   {48'h0, model_lane(3, 16'h8000)}, 64'hF000);
        check("pin_sig_interp", {48'h0, model_lane(2, 16'h0200)}, 64'h087F);
        check("pin_tanh_floor", {48'h0, model_lane(3, 16'hFE00)}, 64'hFE0A);
        check("pin_relu_neg",   {48'h0, model_lane(1, 16'hF000)}, 64'h0000);
        check("pin_relu_pos",   {48'h0, model_lane(1, 16'h1234)}, 64'h1234);

        // reset held with valid asserted; first beat lands three register stages after its accept edge
        n_rst     = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd2;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge tb_clk);
        #1;
        check("rst_valid", {63'h0, out_valid}, 64'h0);
        check("rst_data", out_data, 64'h0);
        @(negedge tb_clk);
        #2 n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge tb_clk);
            #1;
            check("first_latency", {63'h0, out_valid}, {63'h0, k == 3});
        end
        check("first_sig0", out_data, 64'h0800_0800_0800_0800);
        in_valid = 1'b0;
        repeat (6) @(posedge tb_clk);
        #1;

        // streaming sigmoid boundaries, lanes differing
        vecs.push_back('{2'd2, 64'h0000_0000_0000_0000});
        vecs.push_back('{2'd2, 64'h8000_8000_8000_8000});
        vecs.push_back('{2'd2, 64'h7FFF_7FFF_7FFF_7FFF});
        vecs.push_back('{2'd2, 64'h7FFF_8000_0200_0000});
        vecs.push_back('{2'd3, 64'hFE00_0000_8000_7FFF});
        run_stream(100, 0, 200);

        // mode changes every beat on x = -1.0
        vecs.push_back('{2'd1, 64'hF000_F000_F000_F000});
        vecs.push_back('{2'd3, 64'hF000_F000_F000_F000});
        vecs.push_back('{2'd0, 64'hF000_F000_F000_F000});
        vecs.push_back('{2'd2, 64'hF000_F000_F000_F000});
        run_stream(100, 0, 200);

        // backpressure with a fixed ready pattern
        for (int b = 0; b < 10; b++) begin
            logic [1:0] m;
            m = 2'(b % 4);
            vecs.push_back('{m, {16'(b * 3001), 16'(b * 1234 + 7), 16'(16'h8000 + b), 16'(-b * 999)}});
        end
        run_stream(100, 1, 400);

        // mid-stream reset with three beats in flight
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_mode  = 2'(k + 1);
            in_data  = {4{16'(k * 16'h1111)}};
            @(posedge tb_clk);
            #1;
        end
        in_valid = 1'b0;
        check("inflight_valid", {63'h0, out_valid}, 64'h1);
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_valid", {63'h0, out_valid}, 64'h0);
        check("async_rst_data", out_data, 64'h0);
        exp_q.delete();
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        #2 n_rst = 1'b1;
        repeat (8) @(posedge tb_clk);
        #1;

        // random sweep with random valid and ready
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] m;
            m = 2'($urandom_range(3));
            vecs.push_back('{m, {$urandom, $urandom}});
        end
        run_stream(70, 2, 20000);

        repeat (4) @(posedge tb_clk);
        #1;
        check("drain_empty", {63'h0, out_valid}, 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
